// File: rtl/alu4_share_ctl.sv
// alu4_share_ctl: round-robin controller sharing one 4-bit ALU among NREQ requesters; define ALU4_SHARE_CTL_DIVIDE_EN to build the iterative signed divider.
module alu4_share_ctl #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [3*NREQ-1:0]    req_op,
  input  logic [4*NREQ-1:0]    req_a,
  input  logic [4*NREQ-1:0]    req_b,
  output logic [NREQ-1:0]      ack,
  output logic [3:0]           result,
  output logic                 err,
  output logic                 busy
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
`ifdef ALU4_SHARE_CTL_DIVIDE_EN
    , DIV = 2'd3
`endif
  } state_t;
  state_t          state_q;
  logic [IW-1:0]   ptr_q, gnt_q, win_d, ptr_d, idx_d;
  logic            any_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [3:0]      result_q;
  logic            err_q;
  logic [2:0]      op_v [NREQ];
  logic [3:0]      a_v [NREQ];
  logic [3:0]      b_v [NREQ];
  logic [2:0]      op_s;
  logic [3:0]      a_s, b_s, alu_s;
  logic            is_div;
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_v[i] = req_op[3*i +: 3];
    assign a_v[i]  = req_a[4*i +: 4];
    assign b_v[i]  = req_b[4*i +: 4];
  end
  // Lowest offset from the pointer wins, so scan offsets from the top down.
  always_comb begin
    any_d = 1'b0;
    win_d = '0;
    idx_d = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx_d = IW'((int'(ptr_q) + k) % NREQ);
      if (req_valid[idx_d]) begin
        any_d = 1'b1;
        win_d = idx_d;
      end
    end
    ptr_d = IW'((int'(win_d) + 1) % NREQ);
  end
  assign op_s   = op_v[gnt_q];
  assign a_s    = a_v[gnt_q];
  assign b_s    = b_v[gnt_q];
  assign ack_d  = NREQ'(1) << gnt_q;
  assign is_div = (op_s == 3'd5) || (op_s == 3'd6);
  assign alu_s  = (op_s == 3'd0) ? a_s ^ b_s :
                  (op_s == 3'd1) ? a_s & b_s :
                  (op_s == 3'd2) ? a_s | b_s :
                  (op_s == 3'd3) ? {3'b000, $signed(a_s) < $signed(b_s)} :
                  (op_s == 3'd4) ? a_s * b_s :
                  (op_s == 3'd7) ? ~(a_s ^ b_s) : 4'd0;
`ifdef ALU4_SHARE_CTL_DIVIDE_EN
  logic [3:0] dvd_q, dsr_q, rem_q, quo_q, rem_n, quo_n, div_res;
  logic [4:0] rs;
  logic [1:0] cnt_q;
  logic       neg_r_q, neg_q_q, mod_q, ge;
  function automatic logic [3:0] mag(input logic [3:0] x);
    return x[3] ? -x : x;
  endfunction
  // Magnitude of -8 is 4'b1000 unsigned, so -8/-1 lands on 4'b1000 naturally.
  assign rs      = {rem_q, dvd_q[3]};
  assign ge      = rs >= {1'b0, dsr_q};
  assign rem_n   = ge ? 4'(rs - {1'b0, dsr_q}) : rs[3:0];
  assign quo_n   = {quo_q[2:0], ge};
  assign div_res = (dsr_q == 4'd0) ? 4'd0 :
                   mod_q ? (neg_r_q ? -rem_n : rem_n) :
                   (neg_q_q ? -quo_n : quo_n);
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      result_q <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (any_d) begin
          gnt_q   <= win_d;
          ptr_q   <= ptr_d;
          state_q <= ISSUE;
        end
        ISSUE: begin
`ifdef ALU4_SHARE_CTL_DIVIDE_EN
          if (is_div) begin
            dvd_q   <= mag(a_s);
            dsr_q   <= mag(b_s);
            rem_q   <= 4'd0;
            quo_q   <= 4'd0;
            cnt_q   <= 2'd0;
            neg_r_q <= a_s[3];
            neg_q_q <= a_s[3] ^ b_s[3];
            mod_q   <= (op_s == 3'd5);
            state_q <= DIV;
          end else
`endif
          begin
            result_q <= is_div ? 4'd0 : alu_s;
            err_q    <= is_div;
            ack_q    <= ack_d;
            state_q  <= DONE;
          end
        end
`ifdef ALU4_SHARE_CTL_DIVIDE_EN
        DIV: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          dvd_q <= dvd_q << 1;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            result_q <= div_res;
            err_q    <= (dsr_q == 4'd0);
            ack_q    <= ack_d;
            state_q  <= DONE;
          end
        end
`endif
        DONE: begin
          ack_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ack    = ack_q;
  assign result = result_q;
  assign err    = err_q;
  assign busy   = (state_q != IDLE);
endmodule
